// File: rtl/song_player_pkg.sv
// rtl/song_player_pkg.sv - shared state enum, note/duration sentinels and default widths for song_player
package song_player_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DUR_W  = 32;

  // ROM sentinels: a zero note is a rest, a zero duration marks the end of a song
  localparam logic [3:0] REST_NOTE    = 4'd0;
  localparam int         END_DURATION = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_GAP    = 3'd3,
    ST_PAUSED = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/player_down_counter.sv
// rtl/player_down_counter.sv - loadable down counter with zero flag, shared by note and gap timing
module player_down_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  input  logic         i_enable,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority; counting stops at zero so an enabled idle counter stays put
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/song_player.sv
// rtl/song_player.sv - song ROM sequencer with gap, pause and stop; LOOP_PLAYBACK_EN repeats the song until stop
module song_player
  import song_player_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DUR_W      = DEF_DUR_W,
  parameter int GAP_CYCLES = 50_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic [3:0]        song_sel,
  output logic [ADDR_W-1:0] rom_address,
  output logic [3:0]        rom_song,
  input  logic [3:0]        rom_note,
  input  logic [DUR_W-1:0]  rom_duration,
  output logic [3:0]        note_out,
  output logic              playing,
  output logic              done
);

  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [DUR_W-1:0] GAP_LOAD = HAS_GAP ? DUR_W'(GAP_CYCLES - 1) : '0;

  // End of song either parks the ROM address (one-shot) or rewinds it (loop)
`ifdef LOOP_PLAYBACK_EN
  localparam logic [ADDR_W-1:0] END_ADDR  = '0;
  localparam state_t            DONE_NEXT = ST_FETCH;
`else
  localparam logic [ADDR_W-1:0] END_ADDR  = '1;
  localparam state_t            DONE_NEXT = ST_IDLE;
`endif

  state_t              r_state;
  state_t              r_resume;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_song;
  logic [3:0]          r_note;

  state_t              w_state_nxt;
  state_t              w_resume_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [3:0]          w_song_nxt;
  logic [3:0]          w_note_nxt;
  logic                w_cnt_load;
  logic [DUR_W-1:0]    w_cnt_value;
  logic                w_cnt_en;
  logic                w_cnt_zero;

  player_down_counter #(
    .W (DUR_W)
  ) u_counter (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_load       (w_cnt_load),
    .i_load_value (w_cnt_value),
    .i_enable     (w_cnt_en),
    .o_zero       (w_cnt_zero)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_resume <= ST_IDLE;
      r_addr   <= '1;
      r_song   <= '0;
      r_note   <= REST_NOTE;
    end else begin
      r_state  <= w_state_nxt;
      r_resume <= w_resume_nxt;
      r_addr   <= w_addr_nxt;
      r_song   <= w_song_nxt;
      r_note   <= w_note_nxt;
    end
  end

  // Next-state, address stepping and counter control
  always_comb begin
    w_state_nxt  = r_state;
    w_resume_nxt = r_resume;
    w_addr_nxt   = r_addr;
    w_song_nxt   = r_song;
    w_note_nxt   = r_note;
    w_cnt_load   = 1'b0;
    w_cnt_value  = '0;
    w_cnt_en     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_song_nxt  = song_sel;
          w_addr_nxt  = '0;
          w_state_nxt = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (rom_duration == DUR_W'(END_DURATION)) begin
          w_addr_nxt  = END_ADDR;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_load  = 1'b1;
          w_cnt_value = rom_duration - DUR_W'(1);
          w_note_nxt  = rom_note;
          w_state_nxt = ST_PLAY;
        end
      end

      ST_PLAY, ST_GAP: begin
        if (!w_cnt_zero) begin
          // The current cycle still counts as played; a pause freezes from the next one
          w_cnt_en = 1'b1;
          if (pause) begin
            w_resume_nxt = r_state;
            w_state_nxt  = ST_PAUSED;
          end
        end else if ((r_state == ST_PLAY) && (r_note != REST_NOTE) && HAS_GAP) begin
          w_cnt_load  = 1'b1;
          w_cnt_value = GAP_LOAD;
          w_state_nxt = ST_GAP;
        end else if (r_addr == '1) begin
          w_addr_nxt  = END_ADDR;
          w_state_nxt = ST_DONE;
        end else begin
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_state_nxt = ST_FETCH;
        end
      end

      ST_PAUSED: begin
        if (!pause) begin
          w_state_nxt = r_resume;
        end
      end

      ST_DONE: begin
        w_state_nxt = DONE_NEXT;
      end

      default: begin
        w_addr_nxt  = '1;
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Stop overrides everything else outside IDLE and never produces a done pulse
    if (stop && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_addr_nxt  = '1;
      w_cnt_load  = 1'b0;
      w_cnt_en    = 1'b0;
    end
  end

  assign rom_address = r_addr;
  assign rom_song    = r_song;
  assign note_out    = (r_state == ST_PLAY) ? r_note : REST_NOTE;
  assign playing     = (r_state == ST_FETCH) || (r_state == ST_PLAY) ||
                       (r_state == ST_GAP)   || (r_state == ST_PAUSED);
  assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_song_player.sv
// tb/tb_song_player.sv - directed self-checking bench for song_player with a small combinational song ROM
module tb_song_player;

  localparam int ADDR_W = 2;
  localparam int DUR_W  = 8;
  localparam int GAP    = 2;

`ifdef LOOP_PLAYBACK_EN
  localparam logic [ADDR_W-1:0] END_ADDR = 2'd0;
`else
  localparam logic [ADDR_W-1:0] END_ADDR = 2'd3;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              pause;
  logic              stop;
  logic [3:0]        song_sel;
  logic [ADDR_W-1:0] rom_address;
  logic [3:0]        rom_song;
  logic [3:0]        rom_note;
  logic [DUR_W-1:0]  rom_duration;
  logic [3:0]        note_out;
  logic              playing;
  logic              done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  song_player #(
    .ADDR_W     (ADDR_W),
    .DUR_W      (DUR_W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pause        (pause),
    .stop         (stop),
    .song_sel     (song_sel),
    .rom_address  (rom_address),
    .rom_song     (rom_song),
    .rom_note     (rom_note),
    .rom_duration (rom_duration),
    .note_out     (note_out),
    .playing      (playing),
    .done         (done)
  );

  // Song 0: {3,4} {0,2} end.  Song 1: {5,3} end.  Song 2: notes 1..4, duration 1, runs off the address space.
  always_comb begin
    rom_note     = 4'd0;
    rom_duration = '0;
    case (rom_song)
      4'd0: begin
        if (rom_address == 2'd0) begin
          rom_note     = 4'd3;
          rom_duration = 8'd4;
        end else if (rom_address == 2'd1) begin
          rom_duration = 8'd2;
        end
      end
      4'd1: begin
        if (rom_address == 2'd0) begin
          rom_note     = 4'd5;
          rom_duration = 8'd3;
        end
      end
      4'd2: begin
        rom_note     = {2'b00, rom_address} + 4'd1;
        rom_duration = 8'd1;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set before this call are sampled on the rising edge, outputs checked on the falling edge
  task automatic cyc(input string tag, input logic [3:0] exp_note, input logic exp_play, input logic exp_done);
    @(negedge clk);
    chk({tag, "_note"},    32'(note_out), 32'(exp_note));
    chk({tag, "_playing"}, 32'(playing),  32'(exp_play));
    chk({tag, "_done"},    32'(done),     32'(exp_done));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    stop     = 1'b0;
    song_sel = 4'd0;

    // Reset values
    @(negedge clk);
    chk("rst_addr",    32'(rom_address), 32'd3);
    chk("rst_song",    32'(rom_song),    32'd0);
    chk("rst_note",    32'(note_out),    32'd0);
    chk("rst_playing", 32'(playing),     32'd0);
    chk("rst_done",    32'(done),        32'd0);
    rst_n = 1'b1;
    cyc("idle", 4'd0, 1'b0, 1'b0);

    // Song 0: note 3 x4, gap x2, rest x2, end
    song_sel = 4'd0;
    start    = 1'b1;
    cyc("t1_fetch0", 4'd0, 1'b1, 1'b0);
    chk("t1_addr0", 32'(rom_address), 32'd0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) cyc("t1_play", 4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc("t1_gap", 4'd0, 1'b1, 1'b0);
    cyc("t1_fetch1", 4'd0, 1'b1, 1'b0);
    chk("t1_addr1", 32'(rom_address), 32'd1);
    for (int i = 0; i < 2; i++) cyc("t1_rest", 4'd0, 1'b1, 1'b0);
    cyc("t1_fetch2", 4'd0, 1'b1, 1'b0);
    chk("t1_addr2", 32'(rom_address), 32'd2);
    cyc("t1_done", 4'd0, 1'b0, 1'b1);
    chk("t1_done_addr", 32'(rom_address), 32'(END_ADDR));
`ifdef LOOP_PLAYBACK_EN
    cyc("t1_refetch", 4'd0, 1'b1, 1'b0);
    chk("t1_refetch_addr", 32'(rom_address), 32'd0);
    chk("t1_refetch_song", 32'(rom_song),    32'd0);
    for (int i = 0; i < 4; i++) cyc("t1_replay", 4'd3, 1'b1, 1'b0);
    stop = 1'b1;
    cyc("t1_stop", 4'd0, 1'b0, 1'b0);
    stop = 1'b0;
`else
    cyc("t1_idle", 4'd0, 1'b0, 1'b0);
`endif
    chk("t1_idle_addr", 32'(rom_address), 32'd3);

    // Pause sampled at the edge closing the first PLAY cycle, held for 5 edges
    start = 1'b1;
    cyc("t2_fetch", 4'd0, 1'b1, 1'b0);
    start = 1'b0;
    cyc("t2_play1", 4'd3, 1'b1, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) cyc("t2_paused", 4'd0, 1'b1, 1'b0);
    pause = 1'b0;
    for (int i = 0; i < 3; i++) cyc("t2_resume", 4'd3, 1'b1, 1'b0);
    cyc("t2_gap", 4'd0, 1'b1, 1'b0);

    // Stop during GAP: IDLE next cycle, address parked, no done pulse
    stop = 1'b1;
    cyc("t3_stop", 4'd0, 1'b0, 1'b0);
    chk("t3_addr", 32'(rom_address), 32'd3);
    stop = 1'b0;
    cyc("t3_after", 4'd0, 1'b0, 1'b0);

    // song_sel sampled only on start; start while playing is ignored
    song_sel = 4'd1;
    start    = 1'b1;
    cyc("t4_fetch", 4'd0, 1'b1, 1'b0);
    chk("t4_song", 32'(rom_song), 32'd1);
    start    = 1'b0;
    song_sel = 4'd0;
    cyc("t4_play1", 4'd5, 1'b1, 1'b0);
    start = 1'b1;
    cyc("t4_ignored", 4'd5, 1'b1, 1'b0);
    chk("t4_song_kept", 32'(rom_song),    32'd1);
    chk("t4_addr_kept", 32'(rom_address), 32'd0);
    start = 1'b0;
    cyc("t4_play3", 4'd5, 1'b1, 1'b0);
    cyc("t4_gap", 4'd0, 1'b1, 1'b0);
    stop = 1'b1;
    cyc("t4_stop", 4'd0, 1'b0, 1'b0);
    stop = 1'b0;

    // Asynchronous reset mid-PLAY, then no playback without a new start
    song_sel = 4'd1;
    start    = 1'b1;
    cyc("t5_fetch", 4'd0, 1'b1, 1'b0);
    start = 1'b0;
    cyc("t5_play", 4'd5, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_note",    32'(note_out),    32'd0);
    chk("t5_rst_playing", 32'(playing),     32'd0);
    chk("t5_rst_done",    32'(done),        32'd0);
    chk("t5_rst_addr",    32'(rom_address), 32'd3);
    chk("t5_rst_song",    32'(rom_song),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("t5_quiet", 4'd0, 1'b0, 1'b0);
    chk("t5_quiet_addr", 32'(rom_address), 32'd3);

    // Song 2 walks addresses 0..3 and ends on address wrap
    song_sel = 4'd2;
    start    = 1'b1;
    cyc("t6_fetch", 4'd0, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc("t6_play", 4'(k + 1), 1'b1, 1'b0);
      cyc("t6_gap1", 4'd0, 1'b1, 1'b0);
      cyc("t6_gap2", 4'd0, 1'b1, 1'b0);
      if (k < 3) begin
        cyc("t6_fetch_n", 4'd0, 1'b1, 1'b0);
        chk("t6_addr", 32'(rom_address), 32'(k + 1));
      end
    end
    cyc("t6_done", 4'd0, 1'b0, 1'b1);
    chk("t6_done_addr", 32'(rom_address), 32'(END_ADDR));
    stop = 1'b1;
    cyc("t6_idle", 4'd0, 1'b0, 1'b0);
    chk("t6_idle_addr", 32'(rom_address), 32'd3);
    stop = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_player.md
SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning the song ROM address width.
REQ-002 SHALL have parameter DUR_W, default 32, meaning the note-duration width in clk cycles.
REQ-003 SHALL have parameter GAP_CYCLES, default 50_000, meaning the silent articulation gap after each nonzero note.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1, meaning a one-cycle pulse that begins playback of song_sel from address 0.
REQ-007 SHALL have port pause, input, 1, meaning a level that freezes playback while high.
REQ-008 SHALL have port stop, input, 1, meaning a one-cycle pulse that aborts playback to IDLE.
REQ-009 SHALL have port song_sel, input, 4, meaning the song index, sampled only on start.
REQ-010 SHALL have port rom_address, output, ADDR_W, meaning the address to the song ROM.
REQ-011 SHALL have port rom_song, output, 4, meaning the latched song index to the song ROM.
REQ-012 SHALL have port rom_note, input, 4, meaning the ROM note (0 = rest).
REQ-013 SHALL have port rom_duration, input, DUR_W, meaning the ROM duration in cycles (0 = end of song).
REQ-014 SHALL have port note_out, output, 4, meaning the note to the tone generator (0 = silent).
REQ-015 SHALL have port playing, output, 1, meaning high in FETCH/PLAY/GAP/PAUSED.
REQ-016 SHALL have port done, output, 1, meaning a one-cycle pulse on natural end of song.

Function
REQ-017 SHALL implement states IDLE, FETCH, PLAY, GAP, PAUSED, DONE.
REQ-018 IDLE SHALL drive rom_address = all-ones, so that every start changes the ROM address.
REQ-019 start in IDLE SHALL latch song_sel into rom_song, set rom_address=0 and enter FETCH next cycle.
REQ-020 FETCH SHALL last exactly one cycle and register rom_note/rom_duration at its end, because the ROM is combinational and settles within one cycle.
REQ-021 FETCH with rom_duration==0 SHALL go to DONE; otherwise it SHALL go to PLAY with the counter loaded to rom_duration-1 and note_out=rom_note.
REQ-022 PLAY SHALL decrement the counter each cycle and hold note_out for exactly rom_duration cycles.
REQ-023 At the end of PLAY, a nonzero note with GAP_CYCLES>0 SHALL enter GAP; a rest note or GAP_CYCLES==0 SHALL increment rom_address and enter FETCH.
REQ-024 GAP SHALL force note_out=0 for GAP_CYCLES cycles, then increment rom_address and enter FETCH.
REQ-025 The rom_address increment SHALL go to DONE instead of FETCH when the address would wrap past 2^ADDR_W-1.
REQ-026 DONE SHALL pulse done for one cycle, set note_out=0 and rom_address=all-ones, and go to IDLE.
REQ-027 pause high in PLAY/GAP SHALL enter PAUSED, where the counter freezes and note_out=0; pause low SHALL resume the saved state with the counter and note unchanged.
REQ-028 pause during FETCH SHALL take effect at the following PLAY/GAP cycle.
REQ-029 stop in any non-IDLE state SHALL go to IDLE next cycle with note_out=0 and no done pulse; stop SHALL have priority over start and pause.
REQ-030 start while not IDLE SHALL be ignored.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, rom_address=all-ones, rom_song=0, note_out=0, playing=0, done=0, counter=0.
REQ-032 Reset deassertion mid-song SHALL NOT resume playback; the block waits for start.

Configuration
REQ-033 With LOOP_PLAYBACK_EN defined, end of song (duration 0 or wrap) SHALL pulse done, set rom_address=0 and enter FETCH, keeping rom_song, so playback repeats until stop.
REQ-034 Without LOOP_PLAYBACK_EN, end of song SHALL behave per REQ-026.

Structure
REQ-035 A shared package SHALL hold the state enum, the REST_NOTE=0 and END_DURATION=0 constants, and the default ADDR_W/DUR_W.
REQ-036 One sub-module, player_down_counter (load, enable, zero flag), SHALL be instantiated for both the PLAY and GAP counts.

Verification
REQ-037 Bench SHALL cover: ROM model {note3 dur4, note0 dur2, dur0}, GAP_CYCLES=2, start -> note_out 3 for 4 cycles, 0 for 2 (gap), 0 for 2 (rest), done pulse, playing low.
REQ-038 Bench SHALL cover: pause high for 5 cycles in the 2nd PLAY cycle of dur4 -> note_out 0 for 5 cycles, then 3 for the remaining 3 cycles.
REQ-039 Bench SHALL cover: stop during GAP -> IDLE next cycle, rom_address=all-ones, no done pulse.
REQ-040 Bench SHALL cover: start with song_sel=1, then song_sel changed to 0 mid-song -> rom_song stays 1; start while playing is ignored.
REQ-041 Bench SHALL cover: rst_n low mid-PLAY -> all outputs reset values immediately; no playback after release without start.
REQ-042 Bench SHALL cover: with LOOP_PLAYBACK_EN, the first ROM model -> done pulses and the note sequence repeats from address 0 until stop.
